time_scheduler: RTL and testbench

Event scheduler for the emulated-time datapath. It holds the global emulation time and scans N clock requesters (TX/RX clock instances and similar) for the earliest pending event. It then advances global time to that event and issues a one-cycle step pulse with a grant mask, so every requester whose event matches can fire. It is the block that produces `time_next` for the `clock` instances and sequences when their `cke_out` may assert.

---
 rtl/time_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_time_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_scheduler.sv
// time_scheduler: emulated-time event scheduler.
// Holds the global emulation time, scans N clock requesters one per cycle for
// the earliest pending event, then commits it with a one-cycle step pulse and
// a grant mask covering every requester whose event time equals the minimum.
// Optional feature macro: TIME_SCHED_LIMIT_EN adds a time_limit input and a
// sticky done output; scheduling stops once the next event lies beyond the
// limit.
module time_scheduler #(
  parameter int N          = 4,
  parameter int TIME_WIDTH = 32,
  parameter int IDX_WIDTH  = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef TIME_SCHED_LIMIT_EN
  input  logic [TIME_WIDTH-1:0]   time_limit,
  output logic                    done,
`endif
  input  logic                    en,
  input  logic [N-1:0]            req_valid,
  input  logic [N*TIME_WIDTH-1:0] req_time,
  output logic [TIME_WIDTH-1:0]   emu_time,
  output logic [TIME_WIDTH-1:0]   time_next,
  output logic                    step,
  output logic [N-1:0]            grant,
  output logic                    busy,
  output logic                    err_past
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N - 1);

  state_t                 state;
  logic [IDX_WIDTH-1:0]   idx;
  logic [TIME_WIDTH-1:0]  min_t;
  logic [N-1:0]           tie;
  logic                   found;

  logic [TIME_WIDTH-1:0]  slot_time [N];
  logic [TIME_WIDTH-1:0]  cur_time;
  logic                   cur_valid;
  logic                   cur_past;
  logic [N-1:0]           idx_onehot;
  logic                   last_idx;
  logic [TIME_WIDTH-1:0]  min_next;
  logic [N-1:0]           tie_next;
  logic                   found_next;
  logic                   limit_hit;
  logic                   run_ok;

  // Split the flat request bus into one time word per requester.
  for (genvar i = 0; i < N; i++) begin : g_slot
    assign slot_time[i] = req_time[i*TIME_WIDTH +: TIME_WIDTH];
  end

  assign busy     = (state != IDLE);
  assign last_idx = (idx == LAST_IDX);

  // Evaluate the requester under the scan index against the running minimum.
  always_comb begin
    cur_time   = slot_time[idx];
    cur_valid  = req_valid[idx];
    cur_past   = cur_valid && (cur_time < emu_time);
    idx_onehot = '0;
    idx_onehot[idx] = 1'b1;
    min_next   = min_t;
    tie_next   = tie;
    found_next = found;
    if (cur_valid && !cur_past) begin
      if (!found || (cur_time < min_t)) begin
        min_next   = cur_time;
        tie_next   = idx_onehot;
        found_next = 1'b1;
      end else if (cur_time == min_t) begin
        tie_next   = tie | idx_onehot;
      end
    end
  end

`ifdef TIME_SCHED_LIMIT_EN
  // A committed minimum beyond the limit ends the run; done also blocks restarts.
  always_comb begin
    limit_hit = found_next && (min_next > time_limit);
    run_ok    = en && !done;
  end

  // Sticky completion flag, raised when a scan finds an event past the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else if ((state == SCAN) && last_idx && limit_hit) begin
      done <= 1'b1;
    end
  end
`else
  // Unbounded scheduling: no limit check, enable alone gates the FSM.
  always_comb begin
    limit_hit = 1'b0;
    run_ok    = en;
  end
`endif

  // Scheduler FSM: IDLE -> SCAN (N cycles) -> COMMIT (1 cycle) with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      min_t     <= '0;
      tie       <= '0;
      found     <= 1'b0;
      emu_time  <= '0;
      time_next <= '0;
      step      <= 1'b0;
      grant     <= '0;
      err_past  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          step  <= 1'b0;
          grant <= '0;
          idx   <= '0;
          min_t <= '0;
          tie   <= '0;
          found <= 1'b0;
          if (run_ok) begin
            state <= SCAN;
          end
        end

        SCAN: begin
          if (cur_past) begin
            err_past <= 1'b1;
          end
          if (!last_idx) begin
            idx   <= idx + IDX_WIDTH'(1);
            min_t <= min_next;
            tie   <= tie_next;
            found <= found_next;
          end else begin
            idx <= '0;
            if (found_next && !limit_hit) begin
              state     <= COMMIT;
              step      <= 1'b1;
              grant     <= tie_next;
              time_next <= min_next;
              emu_time  <= min_next;
              min_t     <= min_next;
              tie       <= tie_next;
              found     <= found_next;
            end else begin
              min_t <= '0;
              tie   <= '0;
              found <= 1'b0;
              if (found_next) begin
                state <= IDLE;
              end else begin
                state <= run_ok ? SCAN : IDLE;
              end
            end
          end
        end

        COMMIT: begin
          step  <= 1'b0;
          grant <= '0;
          idx   <= '0;
          min_t <= '0;
          tie   <= '0;
          found <= 1'b0;
          state <= run_ok ? SCAN : IDLE;
        end

        default: begin
          state <= IDLE;
          step  <= 1'b0;
          grant <= '0;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_scheduler.sv
// tb_time_scheduler: directed testbench for time_scheduler with N=4.
// Each task drives one scenario and checks its own expected values inline.
module tb_time_scheduler;

  localparam int N  = 4;
  localparam int TW = 32;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic [N-1:0]    req_valid;
  logic [N*TW-1:0] req_time;
  logic [TW-1:0]   emu_time;
  logic [TW-1:0]   time_next;
  logic            step;
  logic [N-1:0]    grant;
  logic            busy;
  logic            err_past;
`ifdef TIME_SCHED_LIMIT_EN
  logic [TW-1:0]   time_limit;
  logic            done;
`endif

  int checks;
  int errors;

  time_scheduler #(.N(N), .TIME_WIDTH(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef TIME_SCHED_LIMIT_EN
    .time_limit(time_limit),
    .done      (done),
`endif
    .en        (en),
    .req_valid (req_valid),
    .req_time  (req_time),
    .emu_time  (emu_time),
    .time_next (time_next),
    .step      (step),
    .grant     (grant),
    .busy      (busy),
    .err_past  (err_past)
  );

  // Free-running system clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_times(input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                           input logic [TW-1:0] t2, input logic [TW-1:0] t3);
    req_time = {t3, t2, t1, t0};
  endtask

  // Advance edge by edge until step is seen or the budget runs out.
  task automatic wait_step(input int max_cycles, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < max_cycles) begin
      @(posedge clk); #1;
      cycles++;
      if (step === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; req_valid = '0; req_time = '0;
`ifdef TIME_SCHED_LIMIT_EN
    time_limit = '1;
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++; if (emu_time !== 32'd0) begin errors++; $display("[TB] FAIL reset_emu_time got %0d want 0", emu_time); end
    checks++; if (time_next !== 32'd0) begin errors++; $display("[TB] FAIL reset_time_next got %0d want 0", time_next); end
    checks++; if (step !== 1'b0) begin errors++; $display("[TB] FAIL reset_step got %b want 0", step); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant got %b want 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (err_past !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_past got %b want 0", err_past); end
`ifdef TIME_SCHED_LIMIT_EN
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_first_step();
    int cyc; bit seen;
    set_times(10, 30, 20, 40);
    req_valid = 4'b1111;
    en = 1'b1;
    wait_step(20, cyc, seen);
    checks++; if (!seen || cyc != 5) begin errors++; $display("[TB] FAIL first_step_latency got %0d (seen %0b) want 5", cyc, seen); end
    checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL first_step_grant got %b want 0001", grant); end
    checks++; if (time_next !== 32'd10) begin errors++; $display("[TB] FAIL first_step_time_next got %0d want 10", time_next); end
    checks++; if (emu_time !== 32'd10) begin errors++; $display("[TB] FAIL first_step_emu_time got %0d want 10", emu_time); end
  endtask

  task automatic test_tie();
    int cyc; bit seen;
    set_times(50, 20, 20, 60);
    wait_step(20, cyc, seen);
    checks++; if (!seen || cyc != 5) begin errors++; $display("[TB] FAIL tie_period got %0d (seen %0b) want 5", cyc, seen); end
    checks++; if (grant !== 4'b0110) begin errors++; $display("[TB] FAIL tie_grant got %b want 0110", grant); end
    checks++; if (time_next !== 32'd20) begin errors++; $display("[TB] FAIL tie_time_next got %0d want 20", time_next); end
    set_times(100, 200, 300, 400);
    @(posedge clk); #1;
    checks++; if (step !== 1'b0) begin errors++; $display("[TB] FAIL back_to_back_step got %b want 0", step); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL idle_grant got %b want 0000", grant); end
    checks++; if (time_next !== 32'd20) begin errors++; $display("[TB] FAIL time_next_hold got %0d want 20", time_next); end
  endtask

  task automatic test_past();
    int cyc; bit seen;
    wait_step(20, cyc, seen);
    checks++; if (!seen || grant !== 4'b0001 || emu_time !== 32'd100) begin errors++; $display("[TB] FAIL past_setup got grant %b emu %0d want 0001 100", grant, emu_time); end
    checks++; if (err_past !== 1'b0) begin errors++; $display("[TB] FAIL past_flag_early got %b want 0", err_past); end
    set_times(150, 120, 90, 130);
    wait_step(20, cyc, seen);
    checks++; if (!seen || grant !== 4'b0010) begin errors++; $display("[TB] FAIL past_grant got %b (seen %0b) want 0010", grant, seen); end
    checks++; if (time_next !== 32'd120) begin errors++; $display("[TB] FAIL past_time_next got %0d want 120", time_next); end
    checks++; if (err_past !== 1'b1) begin errors++; $display("[TB] FAIL past_flag got %b want 1", err_past); end
  endtask

  task automatic test_reset_mid_scan();
    int cyc; bit seen;
    set_times(40, 41, 42, 43);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (emu_time !== 32'd0 || time_next !== 32'd0) begin errors++; $display("[TB] FAIL async_reset_times got emu %0d next %0d want 0 0", emu_time, time_next); end
    checks++; if (busy !== 1'b0 || err_past !== 1'b0 || step !== 1'b0 || grant !== 4'b0000) begin errors++; $display("[TB] FAIL async_reset_flags got busy %b err %b step %b grant %b want 0 0 0 0000", busy, err_past, step, grant); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_step(20, cyc, seen);
    checks++; if (!seen || cyc != 5) begin errors++; $display("[TB] FAIL post_reset_latency got %0d (seen %0b) want 5", cyc, seen); end
    checks++; if (grant !== 4'b0001 || time_next !== 32'd40) begin errors++; $display("[TB] FAIL post_reset_step got grant %b next %0d want 0001 40", grant, time_next); end
  endtask

  task automatic test_idle_scans();
    int cyc; bit seen; int steps_seen;
    rst_n = 1'b0;
    req_valid = 4'b0000;
    #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    en = 1'b1;
    steps_seen = 0;
    for (int i = 0; i < 3 * (N + 1); i++) begin
      @(posedge clk); #1;
      if (step === 1'b1) steps_seen++;
    end
    checks++; if (steps_seen != 0) begin errors++; $display("[TB] FAIL empty_scan_steps got %0d want 0", steps_seen); end
    checks++; if (busy !== 1'b1 || emu_time !== 32'd0) begin errors++; $display("[TB] FAIL empty_scan_state got busy %b emu %0d want 1 0", busy, emu_time); end
    set_times(500, 500, 500, 7);
    req_valid = 4'b1000;
    wait_step(12, cyc, seen);
    checks++; if (!seen || grant !== 4'b1000) begin errors++; $display("[TB] FAIL single_req_grant got %b (seen %0b) want 1000", grant, seen); end
    checks++; if (time_next !== 32'd7 || emu_time !== 32'd7) begin errors++; $display("[TB] FAIL single_req_time got next %0d emu %0d want 7 7", time_next, emu_time); end
  endtask

  task automatic test_en_low();
    int cyc; bit seen; int steps_seen;
    set_times(8, 9, 10, 11);
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    en = 1'b0;
    wait_step(10, cyc, seen);
    checks++; if (!seen || grant !== 4'b0001 || time_next !== 32'd8) begin errors++; $display("[TB] FAIL en_low_step got grant %b next %0d (seen %0b) want 0001 8", grant, time_next, seen); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL en_low_idle got busy %b want 0", busy); end
    steps_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (step === 1'b1) steps_seen++;
    end
    checks++; if (steps_seen != 0 || emu_time !== 32'd8) begin errors++; $display("[TB] FAIL en_low_quiet got steps %0d emu %0d want 0 8", steps_seen, emu_time); end
  endtask

`ifdef TIME_SCHED_LIMIT_EN
  task automatic test_limit();
    int cyc; bit seen; int steps_seen;
    rst_n = 1'b0;
    en = 1'b0;
    time_limit = 32'd25;
    set_times(10, 30, 40, 50);
    req_valid = 4'b1111;
    #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    en = 1'b1;
    wait_step(20, cyc, seen);
    checks++; if (!seen || grant !== 4'b0001 || time_next !== 32'd10) begin errors++; $display("[TB] FAIL limit_first_step got grant %b next %0d want 0001 10", grant, time_next); end
    set_times(60, 30, 40, 50);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL limit_done got %b want 1", done); end
    steps_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (step === 1'b1) steps_seen++;
    end
    checks++; if (steps_seen != 0 || busy !== 1'b0 || emu_time !== 32'd10) begin errors++; $display("[TB] FAIL limit_stop got steps %0d busy %b emu %0d want 0 0 10", steps_seen, busy, emu_time); end
  endtask
`endif

  // Run every scenario in order, then report the totals.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    @(posedge clk); #1;
    test_first_step();
    test_tie();
    test_past();
    test_reset_mid_scan();
    test_idle_scans();
    test_en_low();
`ifdef TIME_SCHED_LIMIT_EN
    test_limit();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
